// File: rtl/data_mem_ctrl.sv
// ---------------------------------------------------------------------------
// data_mem_ctrl
//   Data memory for the MIPS MEM stage. Supports byte, halfword and word
//   access with sign or zero extension (big-endian lanes), and flags
//   misaligned and out-of-range accesses. After reset the whole array is
//   swept to zero (CLEAR). A valid/ready stream can preload words from
//   index 0 upward (LOAD). Reads are combinational; writes happen on the
//   rising edge of clk.
//
// Ports
//   clk, rst_n            clock, asynchronous active-low reset
//   mem_read, mem_write   load / store request from the MEM stage
//   size                  00 byte, 01 half, 10 word, 11 treated as word
//   ld_unsigned           1 zero-extends sub-word loads, 0 sign-extends
//   addr, wr_data         byte address and store data (low bits for sub-word)
//   rd_data               extended load data, 0 unless a valid load
//   misalign, addr_err    access faults (combinational, 0 while busy)
//   busy                  high in CLEAR or LOAD; the pipeline must stall
//   ld_start              requests a preload stream (sampled in IDLE only)
//   ld_valid, ld_data,
//   ld_last, ld_ready     preload stream handshake
//   ld_done               one-cycle pulse after the final preload word
// ---------------------------------------------------------------------------
module data_mem_ctrl #(
  parameter int DEPTH = 512
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [1:0]  size,
  input  logic        ld_unsigned,
  input  logic [31:0] addr,
  input  logic [31:0] wr_data,
  output logic [31:0] rd_data,
  output logic        misalign,
  output logic        addr_err,
  output logic        busy,
  input  logic        ld_start,
  input  logic        ld_valid,
  input  logic [31:0] ld_data,
  input  logic        ld_last,
  output logic        ld_ready,
  output logic        ld_done
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

  localparam logic [1:0] CLEAR = 2'd0;
  localparam logic [1:0] IDLE  = 2'd1;
  localparam logic [1:0] LOAD  = 2'd2;

  logic [1:0]    state_q, state_d;
  logic [AW-1:0] ptr_q, ptr_d;
  logic          ld_done_q, ld_done_d;

  logic [31:0] mem [DEPTH];

  logic          idle, req, acc_ok;
  logic [AW-1:0] idx;
  logic [31:0]   cur;
  logic [7:0]    lane_b;
  logic [15:0]   lane_h;
  logic [31:0]   rd_val;
  logic [31:0]   st_mask, st_data, st_word;
  logic          we;
  logic [AW-1:0] waddr;
  logic [31:0]   wdata;

  assign idle     = (state_q == IDLE);
  assign busy     = !idle;
  assign ld_ready = (state_q == LOAD);
  assign ld_done  = ld_done_q;
  assign req      = mem_read | mem_write;

  // Fault flags only mean something for a real request outside CLEAR/LOAD.
  assign misalign = idle & req & (((size == 2'b01) & addr[0]) | (size[1] & (addr[1:0] != 2'b00)));
  assign addr_err = idle & req & ((addr >> (AW + 2)) != 32'd0);
  assign acc_ok   = idle & req & !misalign & !addr_err;

  assign idx = addr[AW+1:2];
  assign cur = mem[idx];

  // Big-endian lane select: offset 0 is the most significant byte.
  always_comb begin
    case (addr[1:0])
      2'd0:    lane_b = cur[31:24];
      2'd1:    lane_b = cur[23:16];
      2'd2:    lane_b = cur[15:8];
      default: lane_b = cur[7:0];
    endcase
    lane_h = addr[1] ? cur[15:0] : cur[31:16];
  end

  always_comb begin
    case (size)
      2'b00:   rd_val = {{24{~ld_unsigned & lane_b[7]}}, lane_b};
      2'b01:   rd_val = {{16{~ld_unsigned & lane_h[15]}}, lane_h};
      default: rd_val = cur;
    endcase
  end

  assign rd_data = (acc_ok & mem_read) ? rd_val : 32'd0;

  // Read-modify-write merge: replicate the store data into every lane and
  // let the mask pick the lane(s) addressed.
  always_comb begin
    case (size)
      2'b00: begin
        st_mask = 32'hFF00_0000 >> {addr[1:0], 3'b000};
        st_data = {4{wr_data[7:0]}};
      end
      2'b01: begin
        st_mask = 32'hFFFF_0000 >> {addr[1], 4'b0000};
        st_data = {2{wr_data[15:0]}};
      end
      default: begin
        st_mask = 32'hFFFF_FFFF;
        st_data = wr_data;
      end
    endcase
    st_word = (cur & ~st_mask) | (st_data & st_mask);
  end

  // Single write port shared by the clear sweep, the preload stream and stores.
  always_comb begin
    we    = 1'b0;
    waddr = idx;
    wdata = st_word;
    case (state_q)
      CLEAR: begin
        we    = 1'b1;
        waddr = ptr_q;
        wdata = 32'd0;
      end
      LOAD: begin
        we    = ld_valid;
        waddr = ptr_q;
        wdata = ld_data;
      end
      IDLE:    we = acc_ok & mem_write;
      default: we = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    ld_done_d = 1'b0;
    case (state_q)
      CLEAR: begin
        if (ptr_q == LAST) begin
          state_d = IDLE;
          ptr_d   = '0;
        end else begin
          ptr_d = ptr_q + AW'(1);
        end
      end
      IDLE: begin
        if (ld_start) begin
          state_d = LOAD;
          ptr_d   = '0;
        end
      end
      LOAD: begin
        if (ld_valid) begin
          // Stop at the last word of the array so the pointer never wraps.
          if (ld_last || ptr_q == LAST) begin
            state_d   = IDLE;
            ptr_d     = '0;
            ld_done_d = 1'b1;
          end else begin
            ptr_d = ptr_q + AW'(1);
          end
        end
      end
      default: begin
        state_d = CLEAR;
        ptr_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= CLEAR;
      ptr_q     <= '0;
      ld_done_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      ld_done_q <= ld_done_d;
    end
  end

endmodule
